i2c_slave: RTL

- 7-bit-address I2C target. It is the responder end of the bus that the team's I2C master drives.
- Operates on the system clock by synchronizing and edge-detecting SCL/SDA. It never drives SCL (no clock stretching).
- Presents received write bytes as a one-cycle-valid byte stream and requests transmit bytes for read transfers.
- Sits between the external I2C pins and a register-map or FIFO client.

---
 rtl/i2c_slave.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target running on the system clock (oversampled SCL/SDA, no clock stretching).
// Define I2C_SLAVE_GLITCH_FILTER_EN to require 3 stable clocks before SCL/SDA changes are accepted.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy,
  output logic       nack_rx,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_raw, sda_raw, scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d, rw_q, rw_d, busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       addr_hit_q, addr_hit_d, nack_rx_q, nack_rx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
    end
  end

  assign scl_raw = scl_sync_q[SYNC_STAGES-1];
  assign sda_raw = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // A new level is accepted only after it differs from the filtered one for 3 clocks in a row.
  logic       scl_filt_q, sda_filt_q;
  logic [1:0] scl_cnt_q, sda_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= 2'd0;
      sda_cnt_q  <= 2'd0;
    end else begin
      if (scl_raw == scl_filt_q) scl_cnt_q <= 2'd0;
      else if (scl_cnt_q == 2'd2) begin
        scl_filt_q <= scl_raw;
        scl_cnt_q  <= 2'd0;
      end else scl_cnt_q <= scl_cnt_q + 2'd1;
      if (sda_raw == sda_filt_q) sda_cnt_q <= 2'd0;
      else if (sda_cnt_q == 2'd2) begin
        sda_filt_q <= sda_raw;
        sda_cnt_q  <= 2'd0;
      end else sda_cnt_q <= sda_cnt_q + 2'd1;
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      nack_rx_q  <= 1'b0;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      addr_hit_q <= addr_hit_d;
      nack_rx_q  <= nack_rx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    addr_hit_d = 1'b0;
    nack_rx_d  = 1'b0;
    if (start_det) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd7;
      state_d   = S_ADDR;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            if (shift_q[6:0] == SLAVE_ADDR) begin
              rw_d    = sda_s;
              state_d = S_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        // First fall drives the ACK; the fall after it ends the ACK bit.
        S_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d   = 1'b1;
            addr_hit_d = 1'b1;
            busy_d     = 1'b1;
          end else if (rw_q) begin
            sda_oe_d  = ~tx_data[7];
            shift_d   = {tx_data[6:0], 1'b0};
            bit_cnt_d = 3'd7;
            state_d   = S_RD_BYTE;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = S_WR_BYTE;
          end
        end else if (scl_rise && sda_oe_q && rw_q) begin
          tx_req_d = 1'b1;
        end
        S_WR_BYTE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            rx_data_d  = {shift_q[6:0], sda_s};
            rx_valid_d = 1'b1;
            state_d    = S_WR_ACK;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) sda_oe_d = 1'b1;
          else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = S_WR_BYTE;
          end
        end
        // Bit 7 is already on the bus on entry; each fall presents the next bit.
        S_RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q != 3'd0) begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = S_RD_ACK;
          end
        end
        S_RD_ACK: if (scl_rise) begin
          if (!sda_s) tx_req_d = 1'b1;
          else begin
            nack_rx_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end else if (scl_fall) begin
          sda_oe_d  = ~tx_data[7];
          shift_d   = {tx_data[6:0], 1'b0};
          bit_cnt_d = 3'd7;
          state_d   = S_RD_BYTE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_req      = tx_req_q;
  assign addr_hit    = addr_hit_q;
  assign rw          = rw_q;
  assign busy        = busy_q;
  assign nack_rx     = nack_rx_q;
  assign dbg_state_o = state_q;

endmodule
